execute_stage: RTL and testbench
================================

# execute_stage

Execute (EX) stage of the 5-stage pipeline. It sits between the decode/register-read stage and `mem_access`. It computes ALU results, branch/jump targets and RV32M multiply/divide results. It also owns the EX/MEM pipeline register that drives every `*_pype2` input of `mem_access`. Division runs on an iterative 32-step engine that stalls upstream through `ex_busy`; all other operations complete in one cycle.

## Interface
Parameters:
- `DIV_STEPS`, default 32: number of divider iterations; fixed at 32 for RV32.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `keep`  in  1  downstream stall; freezes the EX/MEM register and the divider.
- `nop`  in  1  branch flush; bubbles the EX/MEM register and aborts any divide.
- `RegWrite_pype1`  in  1  decoded control.
- `MemBranch_pype1`  in  3  decoded control, `MEMB_*` code.
- `MemtoReg_pype1`  in  2  decoded control.
- `MemRW_pype1`  in  2  decoded control.
- `alu_op_pype1`  in  5  `ALU_*` code.
- `alu_src_pype1`  in  1  1: operand B = `imm_pype1`; 0: operand B = `rs2_pype1`.
- `jalr_pype1`  in  1  target = (rs1 + imm) & ~1; otherwise PC + imm.
- `rs1_pype1`, `rs2_pype1`, `imm_pype1`, `PC_pype1`, `PCp4_pype1`, `Instraction_pype1`  in  32 each  operands, already forwarded.
- `WReg_pype1`  in  5  destination register.
- `RegWrite_pype2`, `MemBranch_pype2`, `MemtoReg_pype2`, `MemRW_pype2`, `WReg_pype2`  out  as the matching input  registered copies.
- `ALU_co_pype`  out  32  registered result.
- `PCBranch_pype2`  out  32  registered branch target.
- `read_data2_pype2`  out  32  registered `rs2_pype1`, store data.
- `PCp4_pype2`, `Instraction_pype2`  out  32  registered copies.
- `ex_busy`  out  1  combinational; upstream must hold its pipeline register while high.

## Operation
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount = B[4:0]), SLT, SLTU, LUI (pass B), MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Branch operands follow the `mem_access` decode:
  - BEQ/BNE: decoder issues SUB, so result == 0 means equal.
  - BLT: decoder issues SLT; BLTU issues SLTU; result 1 means taken.
  - BGE: decoder issues SLT; taken when result == 0.
- JAL/JALR: result = `PCp4_pype1`; `PCBranch_pype2` = target.
- `PCBranch_pype2` is computed for every instruction.
- Multiplies: single-cycle 32×32→64. Low or high half is selected by the op; signedness is per operand.
- Divider FSM has three states: IDLE, DIV, DONE.
  - IDLE → DIV: a DIV/DIVU/REM/REMU op is present, `keep`=0 and `nop`=0. On that edge the FSM latches absolute operands and sign flags and sets count = 0.
  - DIV: one restoring shift-subtract step per cycle. When count = 31 the FSM moves to DONE.
  - DONE: applies sign correction. The EX/MEM register loads the result at the end of this cycle. Next state is IDLE.
- Divide special cases are decided in IDLE and go straight to DONE:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / −1: quotient 0x80000000, remainder 0.
- `ex_busy` = 1 in IDLE with a divide op present, and in DIV. It is 0 in DONE and otherwise.
- While `ex_busy` = 1 the EX/MEM register loads a bubble:
  - RegWrite, MemRW, MemtoReg and WReg are zeroed.
  - MemBranch is set to `MEMB_NONE`.
- Update priority of the EX/MEM register and FSM: `rst` low > `nop` > `keep` > normal load.
  - `nop` bubbles the register, zeroes the datapath fields and forces the FSM to IDLE.
  - `keep` holds the register, the FSM state and the count.

## Timing
- Reset: every output register is 0, MemBranch = `MEMB_NONE`, FSM in IDLE, `ex_busy` = 0.
- Single-cycle op presented in cycle N appears on the outputs after edge N.
- Divide presented in cycle N, with no `keep`:
  - `ex_busy` is high for cycles N to N+32 (33 cycles).
  - The result appears on the outputs after edge N+33.
  - Bubbles appear on the outputs after edges N to N+32.
- Special-case divide: `ex_busy` high for cycle N only; result after edge N+1.
- Each `keep` cycle during a divide extends the latency by exactly one cycle.
- `nop` in any divider state discards the divide. The next cycle is IDLE with `ex_busy` = 0 unless a new divide op is present.
- `rst` asserted mid-divide returns to IDLE asynchronously.

## Structure
- `define.v` holds the `MEMB_*` codes (including `MEMB_NONE` = 0) and the `ALU_*` 5-bit op codes. They are shared with decode and `mem_access`.
- One sub-module, `serial_divider`: the FSM, counter, 64-bit remainder/quotient shift register and sign fix-up.
  - Interface: `start`, `hold`, `abort`, `signed_op`, `rem_sel`, `a`, `b`, `busy`, `done`, `result`.

## Test plan
- ADD 5 + (−7) with `alu_src`=0 → `ALU_co_pype` = 0xFFFFFFFE one edge later; `RegWrite_pype2` = 1.
- BLT with rs1 = −1, rs2 = 1 (SLT), PC = 0x100, imm = 0x20 → `ALU_co_pype` = 1 and `PCBranch_pype2` = 0x120.
- DIV −100 / 7 → `ex_busy` high for 33 cycles; result 0xFFFFFFF2 (−14) after 34 edges; REM gives −2.
- DIVU 10 / 0 → 0xFFFFFFFF after 2 edges. DIV 0x80000000 / −1 → 0x80000000.
- DIVU 100 / 3 with `keep` high for 3 cycles mid-divide → result 33 delayed exactly 3 cycles; outputs frozen during `keep`.
- `nop` at count 10 of a divide → bubble output next edge and FSM IDLE; a following ADD 1 + 1 completes normally with result 2.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared op codes for the EX stage: ALU op codes, MemBranch codes and divider states.
package execute_stage_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    // JAL and JALR share MEMB_JAL; jalr_pype1 picks the target form.
    localparam logic [2:0] MEMB_NONE = 3'd0;
    localparam logic [2:0] MEMB_BEQ  = 3'd1;
    localparam logic [2:0] MEMB_BNE  = 3'd2;
    localparam logic [2:0] MEMB_BLT  = 3'd3;
    localparam logic [2:0] MEMB_BGE  = 3'd4;
    localparam logic [2:0] MEMB_BLTU = 3'd5;
    localparam logic [2:0] MEMB_BGEU = 3'd6;
    localparam logic [2:0] MEMB_JAL  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->EX inputs and EX/MEM register outputs of the execute stage.
interface execute_stage_if;
    logic        keep;
    logic        nop;
    logic        RegWrite_pype1;
    logic [2:0]  MemBranch_pype1;
    logic [1:0]  MemtoReg_pype1;
    logic [1:0]  MemRW_pype1;
    logic [4:0]  alu_op_pype1;
    logic        alu_src_pype1;
    logic        jalr_pype1;
    logic [31:0] rs1_pype1;
    logic [31:0] rs2_pype1;
    logic [31:0] imm_pype1;
    logic [31:0] PC_pype1;
    logic [31:0] PCp4_pype1;
    logic [31:0] Instraction_pype1;
    logic [4:0]  WReg_pype1;
    logic        RegWrite_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [1:0]  MemtoReg_pype2;
    logic [1:0]  MemRW_pype2;
    logic [4:0]  WReg_pype2;
    logic [31:0] ALU_co_pype;
    logic [31:0] PCBranch_pype2;
    logic [31:0] read_data2_pype2;
    logic [31:0] PCp4_pype2;
    logic [31:0] Instraction_pype2;
    logic        ex_busy;

    modport slave (
        input  keep, nop, RegWrite_pype1, MemBranch_pype1, MemtoReg_pype1, MemRW_pype1,
               alu_op_pype1, alu_src_pype1, jalr_pype1, rs1_pype1, rs2_pype1, imm_pype1,
               PC_pype1, PCp4_pype1, Instraction_pype1, WReg_pype1,
        output RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2, MemRW_pype2, WReg_pype2,
               ALU_co_pype, PCBranch_pype2, read_data2_pype2, PCp4_pype2, Instraction_pype2,
               ex_busy
    );

    modport master (
        output keep, nop, RegWrite_pype1, MemBranch_pype1, MemtoReg_pype1, MemRW_pype1,
               alu_op_pype1, alu_src_pype1, jalr_pype1, rs1_pype1, rs2_pype1, imm_pype1,
               PC_pype1, PCp4_pype1, Instraction_pype1, WReg_pype1,
        input  RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2, MemRW_pype2, WReg_pype2,
               ALU_co_pype, PCBranch_pype2, read_data2_pype2, PCp4_pype2, Instraction_pype2,
               ex_busy
    );
endinterface

// File: rtl/execute_stage_serial_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with sign fix-up.
//   state  | meaning
//   S_IDLE | waiting for a divide; special cases resolved here
//   S_DIV  | one shift-subtract step per cycle, count 0..DIV_STEPS-1
//   S_DONE | sign-corrected result valid on result
module serial_divider
    import execute_stage_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic        abort,
    input  logic        signed_op,
    input  logic        rem_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    div_state_e  state;
    logic [4:0]  count;
    logic [31:0] rem_q, quo_q, divisor_q;
    logic        neg_q, neg_r, rem_sel_q;
    logic        a_neg, b_neg, ge;
    logic [31:0] a_abs, b_abs;
    logic [32:0] shifted, trial;

    always_comb begin
        a_neg   = signed_op & a[31];
        b_neg   = signed_op & b[31];
        a_abs   = a_neg ? (~a + 32'd1) : a;
        b_abs   = b_neg ? (~b + 32'd1) : b;
        shifted = {rem_q, quo_q[31]};
        ge      = shifted >= {1'b0, divisor_q};
        trial   = shifted - {1'b0, divisor_q};
    end

    // Special cases preload the final values with sign flags cleared, so DONE passes them through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
        end else if (!hold) begin
            case (state)
                S_IDLE: if (start) begin
                    rem_sel_q <= rem_sel;
                    count     <= 5'd0;
                    if (b == 32'd0) begin
                        quo_q <= 32'hFFFF_FFFF;
                        rem_q <= a;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= S_DONE;
                    end else if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        quo_q <= 32'h8000_0000;
                        rem_q <= 32'd0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        quo_q     <= a_abs;
                        rem_q     <= 32'd0;
                        divisor_q <= b_abs;
                        neg_q     <= a_neg ^ b_neg;
                        neg_r     <= a_neg;
                        state     <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= ge ? trial[31:0] : shifted[31:0];
                    quo_q <= {quo_q[30:0], ge};
                    count <= count + 5'd1;
                    if (count == 5'(DIV_STEPS - 1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = ((state == S_IDLE) && start) || (state == S_DIV);
        done   = (state == S_DONE);
        result = rem_sel_q ? (neg_r ? (~rem_q + 32'd1) : rem_q)
                           : (neg_q ? (~quo_q + 32'd1) : quo_q);
    end
endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch target, RV32M multiply/divide and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input logic clk,
    input logic rst,
    execute_stage_if.slave bus
);
    logic [31:0] op_a, op_b, alu_res, ex_res, target, div_res;
    logic [63:0] prod;
    logic        a_sgn, b_sgn, div_op, div_busy, div_done;

    serial_divider #(.DIV_STEPS(DIV_STEPS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_op),
        .hold      (bus.keep),
        .abort     (bus.nop),
        .signed_op ((bus.alu_op_pype1 == ALU_DIV) || (bus.alu_op_pype1 == ALU_REM)),
        .rem_sel   ((bus.alu_op_pype1 == ALU_REM) || (bus.alu_op_pype1 == ALU_REMU)),
        .a         (op_a),
        .b         (op_b),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_res)
    );

    always_comb begin
        op_a   = bus.rs1_pype1;
        op_b   = bus.alu_src_pype1 ? bus.imm_pype1 : bus.rs2_pype1;
        div_op = is_div_op(bus.alu_op_pype1);
        a_sgn  = (bus.alu_op_pype1 == ALU_MULH) || (bus.alu_op_pype1 == ALU_MULHSU);
        b_sgn  = (bus.alu_op_pype1 == ALU_MULH);
        // Extending to 64 bits and keeping the low 64 product bits gives the exact signed/unsigned result.
        prod   = {{32{a_sgn & op_a[31]}}, op_a} * {{32{b_sgn & op_b[31]}}, op_b};
        case (bus.alu_op_pype1)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $signed(op_a) >>> op_b[4:0];
            ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
            ALU_LUI:    alu_res = op_b;
            ALU_MUL:    alu_res = prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = prod[63:32];
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = div_res;
            default:    alu_res = 32'd0;
        endcase
        ex_res = (bus.MemBranch_pype1 == MEMB_JAL) ? bus.PCp4_pype1 : alu_res;
        target = bus.jalr_pype1 ? ((bus.rs1_pype1 + bus.imm_pype1) & 32'hFFFF_FFFE)
                                : (bus.PC_pype1 + bus.imm_pype1);
        bus.ex_busy = div_busy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWrite_pype2    <= 1'b0;
            bus.MemBranch_pype2   <= MEMB_NONE;
            bus.MemtoReg_pype2    <= 2'd0;
            bus.MemRW_pype2       <= 2'd0;
            bus.WReg_pype2        <= 5'd0;
            bus.ALU_co_pype       <= 32'd0;
            bus.PCBranch_pype2    <= 32'd0;
            bus.read_data2_pype2  <= 32'd0;
            bus.PCp4_pype2        <= 32'd0;
            bus.Instraction_pype2 <= 32'd0;
        end else if (bus.nop) begin
            bus.RegWrite_pype2    <= 1'b0;
            bus.MemBranch_pype2   <= MEMB_NONE;
            bus.MemtoReg_pype2    <= 2'd0;
            bus.MemRW_pype2       <= 2'd0;
            bus.WReg_pype2        <= 5'd0;
            bus.ALU_co_pype       <= 32'd0;
            bus.PCBranch_pype2    <= 32'd0;
            bus.read_data2_pype2  <= 32'd0;
            bus.PCp4_pype2        <= 32'd0;
            bus.Instraction_pype2 <= 32'd0;
        end else if (!bus.keep) begin
            bus.ALU_co_pype       <= ex_res;
            bus.PCBranch_pype2    <= target;
            bus.read_data2_pype2  <= bus.rs2_pype1;
            bus.PCp4_pype2        <= bus.PCp4_pype1;
            bus.Instraction_pype2 <= bus.Instraction_pype1;
            // A divide still in flight reaches MEM as a bubble; DONE is not busy, so the result loads normally.
            if (div_busy) begin
                bus.RegWrite_pype2  <= 1'b0;
                bus.MemBranch_pype2 <= MEMB_NONE;
                bus.MemtoReg_pype2  <= 2'd0;
                bus.MemRW_pype2     <= 2'd0;
                bus.WReg_pype2      <= 5'd0;
            end else begin
                bus.RegWrite_pype2  <= bus.RegWrite_pype1;
                bus.MemBranch_pype2 <= bus.MemBranch_pype1;
                bus.MemtoReg_pype2  <= bus.MemtoReg_pype1;
                bus.MemRW_pype2     <= bus.MemRW_pype1;
                bus.WReg_pype2      <= bus.WReg_pype1;
            end
        end
    end

    logic unused_done;
    assign unused_done = div_done;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: single-cycle op table plus divide, keep, nop and reset sequences.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    execute_stage_if bus();
    execute_stage #(.DIV_STEPS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic        src;
        logic        jalr;
        logic [2:0]  mb;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] res;
        logic [31:0] tgt;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic src, input logic jalr, input logic [2:0] mb,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic rw, input logic [4:0] wr);
        bus.alu_op_pype1      = op;
        bus.alu_src_pype1     = src;
        bus.jalr_pype1        = jalr;
        bus.MemBranch_pype1   = mb;
        bus.rs1_pype1         = rs1;
        bus.rs2_pype1         = rs2;
        bus.imm_pype1         = imm;
        bus.RegWrite_pype1    = rw;
        bus.WReg_pype1        = wr;
        bus.MemtoReg_pype1    = 2'd0;
        bus.MemRW_pype1       = 2'd0;
        bus.PC_pype1          = 32'h100;
        bus.PCp4_pype1        = 32'h104;
        bus.Instraction_pype1 = 32'h0000_0013;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_edges,
                           input int exp_busy, input int kstart, input int klen);
        int          edges = 0;
        int          busy_n = 0;
        bit          got = 0;
        logic [31:0] snap_res;
        logic [2:0]  snap_mb;
        drive(op, 1'b0, 1'b0, MEMB_NONE, a, b, 32'd0, 1'b1, 5'd7);
        #1;
        while (!got && edges < 80) begin
            bus.keep = (edges >= kstart) && (edges < kstart + klen);
            #1;
            if (bus.ex_busy) busy_n++;
            snap_res = bus.ALU_co_pype;
            snap_mb  = bus.MemBranch_pype2;
            @(posedge clk);
            #1;
            edges++;
            if (bus.keep) begin
                chk({nm, " frozen res"}, bus.ALU_co_pype, snap_res);
                chk({nm, " frozen rw"}, {31'd0, bus.RegWrite_pype2}, 32'd0);
                chk({nm, " frozen mb"}, {29'd0, bus.MemBranch_pype2}, {29'd0, snap_mb});
            end else if (bus.RegWrite_pype2) begin
                got = 1;
            end
        end
        bus.keep = 1'b0;
        drive(ALU_ADD, 1'b0, 1'b0, MEMB_NONE, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        chk({nm, " completed"}, {31'd0, got}, 32'd1);
        chk({nm, " edges"}, edges, exp_edges);
        chk({nm, " busy cycles"}, busy_n, exp_busy);
        chk({nm, " result"}, bus.ALU_co_pype, exp);
        chk({nm, " wreg"}, {27'd0, bus.WReg_pype2}, 32'd7);
    endtask

    initial begin
        vt[0]  = '{ALU_ADD,    1'b0, 1'b0, MEMB_NONE, 32'd5,        32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFE, 32'h100};
        vt[1]  = '{ALU_SLT,    1'b0, 1'b0, MEMB_BLT,  32'hFFFF_FFFF, 32'd1,        32'h20,        32'd1,         32'h120};
        vt[2]  = '{ALU_SUB,    1'b0, 1'b0, MEMB_BEQ,  32'd10,       32'd10,        32'h8,         32'd0,         32'h108};
        vt[3]  = '{ALU_SLTU,   1'b0, 1'b0, MEMB_BLTU, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'd0,         32'h100};
        vt[4]  = '{ALU_SRA,    1'b1, 1'b0, MEMB_NONE, 32'h8000_0000, 32'd0,        32'd4,         32'hF800_0000, 32'h104};
        vt[5]  = '{ALU_SLL,    1'b0, 1'b0, MEMB_NONE, 32'd1,        32'h23,        32'd0,         32'd8,         32'h100};
        vt[6]  = '{ALU_SRL,    1'b0, 1'b0, MEMB_NONE, 32'h8000_0000, 32'd31,       32'd0,         32'd1,         32'h100};
        vt[7]  = '{ALU_AND,    1'b0, 1'b0, MEMB_NONE, 32'hF0F0,     32'h0FF0,      32'd0,         32'h00F0,      32'h100};
        vt[8]  = '{ALU_OR,     1'b0, 1'b0, MEMB_NONE, 32'hF0F0,     32'h0FF0,      32'd0,         32'hFFF0,      32'h100};
        vt[9]  = '{ALU_XOR,    1'b0, 1'b0, MEMB_NONE, 32'hF0F0,     32'h0FF0,      32'd0,         32'hFF00,      32'h100};
        vt[10] = '{ALU_LUI,    1'b1, 1'b0, MEMB_NONE, 32'd0,        32'd0,         32'h1234_5000, 32'h1234_5000, 32'h1234_5100};
        vt[11] = '{ALU_MUL,    1'b0, 1'b0, MEMB_NONE, 32'hFFFF_FFFF, 32'd2,        32'd0,         32'hFFFF_FFFE, 32'h100};
        vt[12] = '{ALU_MULH,   1'b0, 1'b0, MEMB_NONE, 32'hFFFF_FFFF, 32'd2,        32'd0,         32'hFFFF_FFFF, 32'h100};
        vt[13] = '{ALU_MULHU,  1'b0, 1'b0, MEMB_NONE, 32'hFFFF_FFFF, 32'd2,        32'd0,         32'd1,         32'h100};
        vt[14] = '{ALU_MULHSU, 1'b0, 1'b0, MEMB_NONE, 32'd2,        32'hFFFF_FFFF, 32'd0,         32'd1,         32'h100};
        vt[15] = '{ALU_ADD,    1'b0, 1'b0, MEMB_JAL,  32'd0,        32'd0,         32'h40,        32'h104,       32'h140};
        vt[16] = '{ALU_ADD,    1'b1, 1'b1, MEMB_JAL,  32'h1001,     32'd0,         32'd4,         32'h104,       32'h1004};
        vt[17] = '{ALU_SLT,    1'b0, 1'b0, MEMB_BGE,  32'd5,        32'd3,         32'hFFFF_FFF0, 32'd0,         32'hF0};

        bus.keep = 1'b0;
        bus.nop  = 1'b0;
        drive(ALU_ADD, 1'b0, 1'b0, MEMB_NONE, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #12;
        chk("reset res", bus.ALU_co_pype, 32'd0);
        chk("reset rw", {31'd0, bus.RegWrite_pype2}, 32'd0);
        chk("reset mb", {29'd0, bus.MemBranch_pype2}, {29'd0, MEMB_NONE});
        chk("reset target", bus.PCBranch_pype2, 32'd0);
        chk("reset busy", {31'd0, bus.ex_busy}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].op, vt[i].src, vt[i].jalr, vt[i].mb, vt[i].rs1, vt[i].rs2, vt[i].imm, 1'b1, 5'(i + 1));
            tick();
            chk($sformatf("vec%0d res", i), bus.ALU_co_pype, vt[i].res);
            chk($sformatf("vec%0d target", i), bus.PCBranch_pype2, vt[i].tgt);
            chk($sformatf("vec%0d rw", i), {31'd0, bus.RegWrite_pype2}, 32'd1);
            chk($sformatf("vec%0d wreg", i), {27'd0, bus.WReg_pype2}, i + 1);
            chk($sformatf("vec%0d mb", i), {29'd0, bus.MemBranch_pype2}, {29'd0, vt[i].mb});
            chk($sformatf("vec%0d store data", i), bus.read_data2_pype2, vt[i].rs2);
        end

        run_div("div -100/7",  ALU_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33, 0, 0);
        run_div("rem -100%7",  ALU_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 33, 0, 0);
        run_div("divu 10/0",   ALU_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 2, 1, 0, 0);
        run_div("remu 10/0",   ALU_REMU, 32'd10, 32'd0, 32'd10, 2, 1, 0, 0);
        run_div("div ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1, 0, 0);
        run_div("rem ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1, 0, 0);
        run_div("divu keep",   ALU_DIVU, 32'd100, 32'd3, 32'd33, 37, 36, 10, 3);
        run_div("divu big",    ALU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 33, 0, 0);

        // nop in the middle of a divide discards it; a following ADD runs normally
        drive(ALU_DIV, 1'b0, 1'b0, MEMB_NONE, 32'd1000, 32'd3, 32'd0, 1'b1, 5'd9);
        for (int k = 0; k < 11; k++) tick();
        chk("nop pre busy", {31'd0, bus.ex_busy}, 32'd1);
        bus.nop = 1'b1;
        tick();
        bus.nop = 1'b0;
        chk("nop bubble rw", {31'd0, bus.RegWrite_pype2}, 32'd0);
        chk("nop bubble res", bus.ALU_co_pype, 32'd0);
        chk("nop bubble wreg", {27'd0, bus.WReg_pype2}, 32'd0);
        drive(ALU_ADD, 1'b0, 1'b0, MEMB_NONE, 32'd1, 32'd1, 32'd0, 1'b1, 5'd3);
        #1;
        chk("nop idle busy", {31'd0, bus.ex_busy}, 32'd0);
        tick();
        chk("post nop add", bus.ALU_co_pype, 32'd2);
        chk("post nop rw", {31'd0, bus.RegWrite_pype2}, 32'd1);

        // asynchronous reset mid-divide
        drive(ALU_DIVU, 1'b0, 1'b0, MEMB_NONE, 32'd77, 32'd5, 32'd0, 1'b1, 5'd4);
        for (int k = 0; k < 5; k++) tick();
        drive(ALU_ADD, 1'b0, 1'b0, MEMB_NONE, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #2;
        chk("mid div busy before rst", {31'd0, bus.ex_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async rst busy", {31'd0, bus.ex_busy}, 32'd0);
        chk("async rst res", bus.ALU_co_pype, 32'd0);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
